// File: rtl/axi4_stream_downsizer.sv
// AXI4-Stream width downsizer: serializes each wide input word LSB slice first,
// trimming empty trailing slices on the final word of a packet.
module axi4_stream_downsizer #(
    parameter int RX_TDATA_WIDTH = 64,
    parameter int TX_TDATA_WIDTH = 16,
    parameter int TID_WIDTH      = 1,
    parameter int TDEST_WIDTH    = 1,
    parameter int TUSER_WIDTH    = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    // wide input stream
    input  logic [RX_TDATA_WIDTH-1:0]   s_tdata_i,
    input  logic [RX_TDATA_WIDTH/8-1:0] s_tkeep_i,
    input  logic [RX_TDATA_WIDTH/8-1:0] s_tstrb_i,
    input  logic                        s_tvalid_i,
    output logic                        s_tready_o,
    input  logic                        s_tlast_i,
    input  logic [TID_WIDTH-1:0]        s_tid_i,
    input  logic [TDEST_WIDTH-1:0]      s_tdest_i,
    input  logic [TUSER_WIDTH-1:0]      s_tuser_i,
    // narrow output stream
    output logic [TX_TDATA_WIDTH-1:0]   m_tdata_o,
    output logic [TX_TDATA_WIDTH/8-1:0] m_tkeep_o,
    output logic [TX_TDATA_WIDTH/8-1:0] m_tstrb_o,
    output logic                        m_tvalid_o,
    input  logic                        m_tready_i,
    output logic                        m_tlast_o,
    output logic [TID_WIDTH-1:0]        m_tid_o,
    output logic [TDEST_WIDTH-1:0]      m_tdest_o,
    output logic [TUSER_WIDTH-1:0]      m_tuser_o
);

    localparam int N     = RX_TDATA_WIDTH / TX_TDATA_WIDTH;
    localparam int IDX_W = $clog2(N);
    localparam int RX_KW = RX_TDATA_WIDTH / 8;
    localparam int TX_KW = TX_TDATA_WIDTH / 8;

    typedef enum logic {EMPTY, SERIALIZE} state_e;

    state_e                    state_q, state_d;
    logic [RX_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [RX_KW-1:0]          tkeep_q, tkeep_d;
    logic [RX_KW-1:0]          tstrb_q, tstrb_d;
    logic                      tlast_q, tlast_d;
    logic [TID_WIDTH-1:0]      tid_q, tid_d;
    logic [TDEST_WIDTH-1:0]    tdest_q, tdest_d;
    logic [TUSER_WIDTH-1:0]    tuser_q, tuser_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          last_idx_q, last_idx_d;

    logic full;
    logic last_slice;
    logic in_hs;
    logic out_hs;

    // Non-final words always emit every slice; a final word stops at its highest
    // slice holding a kept byte, or at slice 0 if nothing is kept at all.
    function automatic logic [IDX_W-1:0] calc_last_idx(input logic            tlast,
                                                       input logic [RX_KW-1:0] keep);
        logic [IDX_W-1:0] r;
        r = IDX_W'(N - 1);
        if (tlast) begin
            r = '0;
            for (int i = 0; i < N; i++) begin
                if (|keep[i*TX_KW +: TX_KW]) r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= EMPTY;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tstrb_q    <= '0;
            tlast_q    <= 1'b0;
            tid_q      <= '0;
            tdest_q    <= '0;
            tuser_q    <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tstrb_q    <= tstrb_d;
            tlast_q    <= tlast_d;
            tid_q      <= tid_d;
            tdest_q    <= tdest_d;
            tuser_q    <= tuser_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
        end
    end

    assign full       = (state_q == SERIALIZE);
    assign last_slice = (idx_q == last_idx_q);
    // Ready is gated by rst_n_i so it drops the instant reset asserts.
    assign s_tready_o = rst_n_i && (!full || (m_tready_i && last_slice));
    assign in_hs      = s_tvalid_i && s_tready_o;
    assign out_hs     = full && m_tready_i;

    always_comb begin
        state_d    = state_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tstrb_d    = tstrb_q;
        tlast_d    = tlast_q;
        tid_d      = tid_q;
        tdest_d    = tdest_q;
        tuser_d    = tuser_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        if (in_hs) begin
            state_d    = SERIALIZE;
            tdata_d    = s_tdata_i;
            tkeep_d    = s_tkeep_i;
            tstrb_d    = s_tstrb_i;
            tlast_d    = s_tlast_i;
            tid_d      = s_tid_i;
            tdest_d    = s_tdest_i;
            tuser_d    = s_tuser_i;
            idx_d      = '0;
            last_idx_d = calc_last_idx(s_tlast_i, s_tkeep_i);
        end else if (out_hs) begin
            if (last_slice) state_d = EMPTY;
            else            idx_d   = idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        m_tdata_o  = tdata_q[int'(idx_q)*TX_TDATA_WIDTH +: TX_TDATA_WIDTH];
        m_tkeep_o  = tkeep_q[int'(idx_q)*TX_KW +: TX_KW];
        m_tstrb_o  = tstrb_q[int'(idx_q)*TX_KW +: TX_KW];
        m_tvalid_o = full;
        m_tlast_o  = full && tlast_q && last_slice;
        m_tid_o    = tid_q;
        m_tdest_o  = tdest_q;
        m_tuser_o  = tuser_q;
    end

endmodule
